// File: rtl/inst_fetch_queue.sv
// Purpose: instruction prefetch queue; issues sequential word fetches and buffers {inst, pc} for decode.
// Latency: 1 cycle from mem_rsp_valid into an empty queue to if_valid; requests are registered.
// Backpressure: if_hold stalls the head; fetch is throttled by a credit cap of DEPTH (buffered + outstanding + pending).
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   mem_req_valid/ready/addr       fetch request channel; a request is held until accepted
//   mem_rsp_valid/data             in-order fetch responses
//   if_valid/if_inst/if_pc         head of queue toward decode (NOP_INST / 0 when empty)
//   if_hold                        decode stall, head is not popped
//   redirect_valid/redirect_pc     flush the queue and restart fetch at redirect_pc
module inst_fetch_queue #(
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [INST_WIDTH-1:0] mem_rsp_data,
    output logic                  if_valid,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  if_hold,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  req_vld_q, req_vld_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      out_q, out_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]      pcq_wr_q, pcq_rd_q;
    logic [CNT_W:0]        credit_sum;
    logic                  issue;

    // Instruction/PC storage and the queue of PCs for requests still in flight.
    logic [INST_WIDTH-1:0] fifo_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [ADDR_WIDTH-1:0] pcq       [DEPTH];

    logic in_run;
    logic accept;
    logic push;
    logic pop;
    logic pcq_push;

    assign in_run   = (state_q == RUN);
    assign accept   = req_vld_q && mem_req_ready;
    assign if_valid = (count_q != '0) && in_run;
    // Redirect wins over push and pop in the same cycle.
    assign push     = in_run && mem_rsp_valid && !redirect_valid;
    assign pop      = if_valid && !if_hold && !redirect_valid;
    // Requests accepted during FLUSH (or in the redirect cycle) are stale: no PC is recorded.
    assign pcq_push = in_run && accept && !redirect_valid;

    assign mem_req_valid = req_vld_q;
    assign mem_req_addr  = req_addr_q;
    assign if_inst       = if_valid ? fifo_inst[rd_ptr_q] : NOP_INST;
    assign if_pc         = if_valid ? fifo_pc[rd_ptr_q]   : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        out_d      = out_q;
        discard_d  = discard_q;
        credit_sum = '0;
        issue      = 1'b0;
        req_vld_d  = req_vld_q;
        req_addr_d = req_addr_q;

        if (in_run) begin
            if (redirect_valid) begin
                fetch_pc_d = redirect_pc;
                count_d    = '0;
                out_d      = '0;
                // Everything still owed by memory becomes stale, including a pending or
                // just-accepted request; a response landing this cycle is dropped here.
                discard_d  = out_q - CNT_W'(mem_rsp_valid) + CNT_W'(req_vld_q);
                state_d    = (discard_d == '0) ? RUN : FLUSH;
            end else begin
                if (accept) begin
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                end
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                out_d   = out_q + CNT_W'(accept) - CNT_W'(mem_rsp_valid);
            end
        end else begin
            // FLUSH: the pending request, if any, is already counted in discard, so its
            // acceptance neither bumps outstanding nor advances fetch_pc.
            if (redirect_valid) begin
                fetch_pc_d = redirect_pc;
            end
            discard_d = discard_q - CNT_W'(mem_rsp_valid);
            if (discard_d == '0) begin
                state_d = RUN;
            end
        end

        // Credit check on post-update occupancy so a new request can follow an acceptance
        // back-to-back without ever exceeding DEPTH slots.
        credit_sum = {1'b0, count_d} + {1'b0, out_d};
        issue = in_run && !redirect_valid && (!req_vld_q || mem_req_ready) &&
                (credit_sum < (CNT_W+1)'(DEPTH));

        if (issue) begin
            req_vld_d  = 1'b1;
            req_addr_d = fetch_pc_d;
        end else if (accept) begin
            req_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            req_vld_q  <= 1'b0;
            req_addr_q <= RESET_PC;
            count_q    <= '0;
            out_q      <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
            if (in_run && redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                pcq_wr_q <= '0;
                pcq_rd_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(push);
                rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
                pcq_wr_q <= pcq_wr_q + PTR_W'(pcq_push);
                pcq_rd_q <= pcq_rd_q + PTR_W'(push);
            end
        end
    end

    // Storage needs no reset: nothing is visible until count/pointers say so.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr_q] <= mem_rsp_data;
            fifo_pc[wr_ptr_q]   <= pcq[pcq_rd_q];
        end
        if (pcq_push) begin
            pcq[pcq_wr_q] <= req_addr_q;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && count_q == CNT_W'(DEPTH)));
    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
        !(in_run && mem_rsp_valid && out_q == '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Purpose: directed self-checking bench for inst_fetch_queue with an in-order memory model.
// Latency: memory answers a fixed number of cycles after each accepted request.
// Backpressure: mem_req_ready and if_hold are driven per cycle by the stimulus.
module tb_inst_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [15:0] if_pc;
    logic        if_hold;
    logic        redirect_valid;
    logic [15:0] redirect_pc;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .INST_WIDTH (32),
        .ADDR_WIDTH (16),
        .DEPTH      (4),
        .RESET_PC   (16'h0000),
        .NOP_INST   (32'h00000013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_hold        (if_hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rsp_t;

    rsp_t        mq[$];
    logic [15:0] acc_log[$];

    typedef struct {
        logic        hold;
        logic        rdy;
        logic        ifv;
        logic [15:0] ifpc;
        logic        rv;
        logic [15:0] raddr;
    } vec_t;

    vec_t vt[18];

    function automatic logic [31:0] mdat(input logic [15:0] a);
        return {16'hAB00, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic v, input logic [15:0] pc);
        check({tag, " if_valid"}, 32'(if_valid), 32'(v));
        check({tag, " if_pc"}, 32'(if_pc), v ? 32'(pc) : 32'h0);
        check({tag, " if_inst"}, if_inst, v ? mdat(pc) : NOP);
    endtask

    task automatic check_req(input string tag, input logic v, input logic [15:0] addr);
        check({tag, " req_valid"}, 32'(mem_req_valid), 32'(v));
        if (v) check({tag, " req_addr"}, 32'(mem_req_addr), 32'(addr));
    endtask

    // Advance one cycle. Handshake is sampled from the settled values of the ending
    // cycle; the response for an acceptance at the end of cycle c is driven in cycle c+lat.
    task automatic tick();
        logic        acc;
        logic [15:0] a;
        rsp_t        r;
        acc = mem_req_valid && mem_req_ready;
        a   = mem_req_addr;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (acc) begin
            r.addr = a;
            r.due  = cyc - 1 + lat;
            mq.push_back(r);
            acc_log.push_back(a);
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mdat(mq[0].addr);
            void'(mq.pop_front());
        end
    endtask

    task automatic do_reset(input int l);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_hold        = 1'b0;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        mq.delete();
        acc_log.delete();
        lat = l;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n8;

        // Startup fill under a long decode stall, then release.
        vt[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0008};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h000C};
        for (int i = 5; i < 12; i++) vt[i] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vt[12] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vt[13] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0010};
        vt[14] = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0014};
        vt[15] = '{1'b0, 1'b1, 1'b1, 16'h000C, 1'b1, 16'h0018};
        vt[16] = '{1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h001C};
        vt[17] = '{1'b0, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h0020};

        // Reset values while rst is held low.
        rst = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; if_hold = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        #12;
        check("reset req_valid", 32'(mem_req_valid), 32'h0);
        check("reset req_addr", 32'(mem_req_addr), 32'h0);
        check_if("reset", 1'b0, 16'h0);

        // A: table-driven fill / stall / drain, memory latency 1.
        do_reset(1);
        for (int i = 0; i < 18; i++) begin
            if_hold       = vt[i].hold;
            mem_req_ready = vt[i].rdy;
            check_if($sformatf("A%0d", i), vt[i].ifv, vt[i].ifpc);
            check_req($sformatf("A%0d", i), vt[i].rv, vt[i].raddr);
            if (i == 11) check("A accepted under hold", 32'(acc_log.size()), 32'd4);
            tick();
        end

        // B: mem_req_ready low for three cycles while 0x8 is pending.
        do_reset(1);
        for (int c = 0; c < 9; c++) begin
            mem_req_ready = !(c >= 3 && c <= 5);
            if (c >= 3 && c <= 5) check_req($sformatf("B%0d stall", c), 1'b1, 16'h0008);
            if (c == 5) check_if("B5 drained", 1'b0, 16'h0);
            if (c == 7) check_req("B7 next", 1'b1, 16'h000C);
            if (c == 8) check_if("B8 head", 1'b1, 16'h0008);
            tick();
        end
        n8 = 0;
        foreach (acc_log[k]) if (acc_log[k] == 16'h0008) n8++;
        check("B accepts of 0x8", 32'(n8), 32'd1);

        // C: redirect with two buffered and two in flight (latency 3).
        do_reset(3);
        if_hold = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check_if("C6 pre", 1'b1, 16'h0000);
        check_req("C6 pre", 1'b0, 16'h0);
        redirect_valid = 1'b1; redirect_pc = 16'h0100; if_hold = 1'b0;
        tick();
        redirect_valid = 1'b0;
        for (int c = 7; c < 14; c++) begin
            if (c <= 12) check_if($sformatf("C%0d flush", c), 1'b0, 16'h0);
            if (c == 7 || c == 8) check_req($sformatf("C%0d quiet", c), 1'b0, 16'h0);
            if (c == 9) check_req("C9 restart", 1'b1, 16'h0100);
            if (c == 10) check_req("C10 next", 1'b1, 16'h0104);
            if (c == 13) check_if("C13 head", 1'b1, 16'h0100);
            tick();
        end

        // D: redirect while a request is pending and not yet accepted.
        do_reset(1);
        mem_req_ready = 1'b0;
        tick();
        check_req("D1 pending", 1'b1, 16'h0000);
        tick();
        check_req("D2 pending", 1'b1, 16'h0000);
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        check_req("D3 held", 1'b1, 16'h0000);
        mem_req_ready = 1'b1;
        tick();
        check_req("D4 done", 1'b0, 16'h0);
        check_if("D4", 1'b0, 16'h0);
        tick();
        check_if("D5 dropped", 1'b0, 16'h0);
        check_req("D5", 1'b0, 16'h0);
        tick();
        check_req("D6 restart", 1'b1, 16'h0200);
        tick();
        check_req("D7 next", 1'b1, 16'h0204);
        tick();
        check_if("D8 head", 1'b1, 16'h0200);

        // Redirect with nothing in flight.
        do_reset(1);
        redirect_valid = 1'b1; redirect_pc = 16'h0300;
        check_req("Z0", 1'b0, 16'h0);
        tick();
        redirect_valid = 1'b0;
        check_req("Z1", 1'b0, 16'h0);
        tick();
        check_req("Z2 restart", 1'b1, 16'h0300);
        tick();
        check_req("Z3 next", 1'b1, 16'h0304);
        tick();
        check_if("Z4 head", 1'b1, 16'h0300);
        check("Z first accept", 32'(acc_log[0]), 32'h0300);

        // E: address wrap at the top of the space, then reset mid-burst.
        do_reset(1);
        redirect_valid = 1'b1; redirect_pc = 16'hFFF8;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_req("E2", 1'b1, 16'hFFF8);
        tick();
        check_req("E3", 1'b1, 16'hFFFC);
        tick();
        check_req("E4 wrap", 1'b1, 16'h0000);
        check_if("E4", 1'b1, 16'hFFF8);
        tick();
        check_if("E5", 1'b1, 16'hFFFC);
        tick();
        check_if("E6", 1'b1, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        check("E rst req_valid", 32'(mem_req_valid), 32'h0);
        check("E rst req_addr", 32'(mem_req_addr), 32'h0);
        check_if("E rst", 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction prefetch stage directly upstream of the IF/ID register.
- Issues sequential word fetches to instruction memory over a valid/ready request channel and receives in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents the head to decode with hold (stall) and redirect (branch-mispredict flush) support.
- Replaces the combinational PC-to-memory path so that memories with multi-cycle latency can be used.

Parameters:
INST_WIDTH, 32, instruction width in bits
ADDR_WIDTH, 16, byte address width of the instruction space
DEPTH, 4, FIFO entries; also the cap on (buffered + outstanding) fetches; power of two, >= 2
RESET_PC, 0, fetch address after reset
NOP_INST, 32'h00000013, value driven on if_inst when no valid instruction is present

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request this cycle
mem_req_addr  output  ADDR_WIDTH  fetch byte address, word aligned
mem_rsp_valid  input  1  response data valid; responses return in request order
mem_rsp_data  input  INST_WIDTH  fetched instruction
if_valid  output  1  if_inst/if_pc hold a valid instruction
if_inst  output  INST_WIDTH  head instruction, or NOP_INST when if_valid=0
if_pc  output  ADDR_WIDTH  PC of head instruction, 0 when if_valid=0
if_hold  input  1  decode stall; head must not be popped
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_WIDTH  new fetch address, word aligned

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO count, outstanding and discard counters cleared; state=RUN.
  - Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, if_valid=0, if_inst=NOP_INST, if_pc=0.
  - Reset mid-transfer discards everything. The memory is reset on the same rst, so no stale responses return afterwards.
- States:
  - RUN: normal fetching.
  - FLUSH: discarding stale responses after a redirect.
- Issue rule:
  - mem_req_valid rises only in RUN, when no request is pending, no redirect is present this cycle, and count + outstanding < DEPTH.
  - mem_req_addr = fetch_pc, registered and stable while valid.
  - Once asserted, mem_req_valid stays high until mem_req_ready is sampled high. A request is never withdrawn, including across a redirect.
  - On acceptance: outstanding+1, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH).
  - Back-to-back requests are allowed: a new request may be presented the cycle after acceptance.
- Response rule, in RUN:
  - mem_rsp_valid pushes {mem_rsp_data, pc} into the FIFO tail.
  - The pc comes from an internal in-flight PC queue of depth DEPTH.
  - outstanding-1.
  - Push when full cannot occur because of the credit rule; an assertion flags it.
- Output:
  - if_valid = (count != 0) && state == RUN; if_inst and if_pc are taken from the head, combinationally from registered FIFO state.
  - Pop when if_valid && !if_hold && !redirect_valid.
  - Push and pop in the same cycle leave count unchanged; read and write pointers wrap modulo DEPTH.
  - A response arriving into an empty FIFO appears on if_valid the next cycle: 1-cycle latency from mem_rsp_valid.
- Redirect (redirect_valid=1), which has priority over push and pop in that cycle:
  - FIFO cleared; fetch_pc = redirect_pc.
  - discard = outstanding (plus 1 if a request is pending unaccepted or accepted this cycle; a response arriving this cycle is not counted).
  - If discard=0, stay in RUN; otherwise enter FLUSH.
  - if_valid goes low the following cycle.
- FLUSH:
  - Each mem_rsp_valid decrements discard and its data is dropped.
  - A pending request completing its handshake does not increment outstanding (it is already counted in discard).
  - No new issue.
  - On the last discarded response, return to RUN and issue from redirect_pc the next cycle.
- Redirect during FLUSH: fetch_pc is replaced with the new redirect_pc, discard is unchanged, and the FSM remains in FLUSH.
- if_hold has no effect on fetching other than back-pressure through the credit rule.

Test Plan:
- Reset release, memory with ready=1 and 1-cycle response latency: requests at 0x0, 0x4, 0x8, 0xC. if_valid rises 2 cycles after the first request; if_pc sequence 0x0, 0x4, ... with matching data. No 5th request until the first pop.
- if_hold=1 for 10 cycles with DEPTH=4: exactly 4 requests issued, count=4, mem_req_valid=0. Releasing hold pops one per cycle and fetch resumes.
- mem_req_ready low for 3 cycles: mem_req_valid and mem_req_addr=0x8 held stable; one acceptance only.
- Redirect to 0x100 with 2 responses outstanding and 2 buffered: both stale responses dropped and if_valid=0 meanwhile. The next request address is 0x100; the next if_pc is 0x100.
- Redirect while a request is pending unaccepted: the request completes, its response is discarded, and fetch restarts at redirect_pc. Redirect with discard=0 issues the new address the next cycle.
- fetch_pc=0xFFFC with ADDR_WIDTH=16: the next request address is 0x0000. Asserting rst mid-burst clears all outputs immediately.
